led_pattern_gen: RTL
====================

Name: led_pattern_gen

Overview:
Parametrised multi-channel LED driver for the PL LED partial-reconfiguration region. It supersedes the fixed-pattern LED modules. It generates OFF, ON, BLINK, CHASE, static-PWM and BREATHE patterns across NUM_LED outputs from a shared prescaled time base. Configuration arrives over a valid/ready port and takes effect only on a tick boundary, so outputs never glitch.

Parameters:
NUM_LED, 2, number of LED outputs (>=1)
TICK_DIV, 50000, clk cycles per time-base tick (>=2)
PWM_W, 8, PWM counter/duty width in bits (>=2)
PERIOD_W, 16, width of step-period field in ticks

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
cfg_valid  input  1  config offer; held with fields stable until accepted
cfg_ready  output  1  block can accept config
cfg_mode  input  3  0 OFF, 1 ON, 2 BLINK, 3 CHASE, 4 PWM, 5 BREATHE, 6/7 treated as OFF
cfg_period  input  PERIOD_W  ticks per pattern step; 0 treated as 1
cfg_duty  input  PWM_W  duty for PWM mode
led  output  NUM_LED  registered LED drive, 1 = lit
cur_mode  output  3  mode currently applied (raw code as loaded)

Behaviour:
- Single clock domain; one asynchronous, active-high reset.
- Reset values: led=0, cur_mode=0, active period=1, active duty=0, cfg_ready=1, all counters=0, pending flag=0. rst asserted mid-operation clears everything immediately; first tick comes TICK_DIV cycles after release.
- Prescaler: free-running 0..TICK_DIV-1. tick is a one-cycle pulse when count == TICK_DIV-1. The prescaler is never reset by a config load.
- Step counter: advances on tick, range 0..period-1. step is a pulse when tick and step_cnt == period-1; the counter then wraps to 0.
- PWM counter: free-running every clk, 0..2^PWM_W-2, wrapping period 2^PWM_W-1. pwm_on = pwm_cnt < duty, so duty 0 = never lit and duty 2^PWM_W-1 = always lit.
- Config handshake:
  - Accept when cfg_valid && cfg_ready. Fields are captured into pending registers and cfg_ready drops the next cycle.
  - Pending config is applied on the first tick strictly after the accept cycle.
  - In the apply cycle: cur_mode/period/duty update; step_cnt=0, blink phase=0, chase one-hot=bit0, breathe duty=0, breathe direction=up. cfg_ready returns to 1 in the cycle after apply.
  - cfg_valid while cfg_ready=0 is ignored (no capture).
- Patterns, evaluated on applied state:
  - OFF / 6 / 7: all 0.
  - ON: all 1.
  - BLINK: phase toggles on each step; led = all bits equal to phase. Starts dark after apply.
  - CHASE: one-hot rotates left one position per step, MSB wraps to bit0. With NUM_LED=1, led stays 1.
  - PWM: all LEDs = pwm_on with the applied duty.
  - BREATHE: breathe duty changes by 1 per step in the current direction. At 2^PWM_W-1 the direction flips to down; at 0 it flips to up. No hold step at either end, so the triangle period is 2*(2^PWM_W-1) steps. All LEDs = (pwm_cnt < breathe duty).
- Latency: led is registered from the pattern decode, so it reflects internal state one clk after that state changes, including after apply.
- Tick and apply in the same cycle: the apply wins. The step counter is cleared rather than advanced, so no step fires that cycle.

Test Plan:
- Reset: NUM_LED=4, running CHASE, assert rst for 1 cycle mid-pattern -> led=0000 and cur_mode=0 during reset with no clk edge needed; cfg_ready=1 after release.
- BLINK: TICK_DIV=4, period=2 -> after apply, led=0000 for 8 clk, then 1111 for 8, then 0000, repeating; cur_mode=2.
- CHASE: NUM_LED=4, TICK_DIV=4, period=1 -> led walks 0001,0010,0100,1000,0001, each held 4 clk.
- PWM: PWM_W=4, duty=5 -> over any 15-cycle window led=1111 for exactly 5 cycles. duty=15 -> constantly 1111; duty=0 -> 0000.
- Handshake: cfg_valid held 1 with mode=1, then a second offer mode=3 while cfg_ready=0 -> only mode 1 applied, on the first tick after accept. cfg_ready is high again the cycle after apply, then mode 3 is accepted.
- Edge configs: period=0 behaves as period=1; mode=7 -> led=0000, cur_mode=7. BREATHE with PWM_W=2, period=1 -> duty sequence 0,1,2,3,2,1,0,1...

Source files
------------

// File: rtl/led_pattern_gen_if.sv
// Configuration and LED drive bundle for led_pattern_gen.
// The master offers a config; the slave (the generator) owns ready and the LED outputs.
interface led_pattern_gen_if #(
  parameter int NUM_LED  = 2,
  parameter int PWM_W    = 8,
  parameter int PERIOD_W = 16
);
  // valid/ready: a config transfers on any cycle where cfg_valid && cfg_ready;
  // the master holds cfg_valid and all cfg_* fields stable until that cycle.
  logic                cfg_valid;
  logic                cfg_ready;
  logic [2:0]          cfg_mode;
  logic [PERIOD_W-1:0] cfg_period;
  logic [PWM_W-1:0]    cfg_duty;
  logic [NUM_LED-1:0]  led;
  logic [2:0]          cur_mode;

  modport master (
    output cfg_valid, cfg_mode, cfg_period, cfg_duty,
    input  cfg_ready, led, cur_mode
  );

  modport slave (
    input  cfg_valid, cfg_mode, cfg_period, cfg_duty,
    output cfg_ready, led, cur_mode
  );
endinterface

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: OFF/ON/BLINK/CHASE/PWM/BREATHE from a shared tick.
// New configs are held pending and applied only on a tick so the LEDs never glitch.
module led_pattern_gen #(
  parameter int NUM_LED  = 2,
  parameter int TICK_DIV = 50000,
  parameter int PWM_W    = 8,
  parameter int PERIOD_W = 16
) (
  input logic              clk,
  input logic              rst,
  led_pattern_gen_if.slave cfg
);
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [PWM_W-1:0] DUTY_MAX = {PWM_W{1'b1}};
  localparam logic [PWM_W-1:0] PWM_LAST = {{(PWM_W-1){1'b1}}, 1'b0};

  localparam logic [2:0] MODE_ON      = 3'd1;
  localparam logic [2:0] MODE_BLINK   = 3'd2;
  localparam logic [2:0] MODE_CHASE   = 3'd3;
  localparam logic [2:0] MODE_PWM     = 3'd4;
  localparam logic [2:0] MODE_BREATHE = 3'd5;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  logic [PRE_W-1:0]    presc_q;
  logic [PWM_W-1:0]    pwm_cnt_q;
  logic [0:0]          state_q,       state_d;
  logic [2:0]          pend_mode_q,   pend_mode_d;
  logic [PERIOD_W-1:0] pend_period_q, pend_period_d;
  logic [PWM_W-1:0]    pend_duty_q,   pend_duty_d;
  logic [2:0]          mode_q,        mode_d;
  logic [PERIOD_W-1:0] period_q,      period_d;
  logic [PWM_W-1:0]    duty_q,        duty_d;
  logic [PERIOD_W-1:0] step_cnt_q,    step_cnt_d;
  logic                phase_q,       phase_d;
  logic [NUM_LED-1:0]  chase_q,       chase_d;
  logic [PWM_W-1:0]    br_duty_q,     br_duty_d;
  logic                br_up_q,       br_up_d;
  logic [NUM_LED-1:0]  led_q,         led_d;

  logic tick, accept, apply, step;

  assign tick   = (presc_q == PRE_LAST);
  assign accept = cfg.cfg_valid && (state_q == ST_IDLE);
  assign apply  = (state_q == ST_PEND) && tick;
  assign step   = tick && (step_cnt_q == period_q - PERIOD_W'(1));

  always_comb begin
    state_d       = state_q;
    pend_mode_d   = pend_mode_q;
    pend_period_d = pend_period_q;
    pend_duty_d   = pend_duty_q;
    mode_d        = mode_q;
    period_d      = period_q;
    duty_d        = duty_q;
    step_cnt_d    = step_cnt_q;
    phase_d       = phase_q;
    chase_d       = chase_q;
    br_duty_d     = br_duty_q;
    br_up_d       = br_up_q;

    if (accept) begin
      state_d       = ST_PEND;
      pend_mode_d   = cfg.cfg_mode;
      pend_period_d = cfg.cfg_period;
      pend_duty_d   = cfg.cfg_duty;
    end

    // Apply takes priority over a coincident tick: pattern state restarts, no step fires.
    if (apply) begin
      state_d    = ST_IDLE;
      mode_d     = pend_mode_q;
      period_d   = (pend_period_q == '0) ? PERIOD_W'(1) : pend_period_q;
      duty_d     = pend_duty_q;
      step_cnt_d = '0;
      phase_d    = 1'b0;
      chase_d    = NUM_LED'(1);
      br_duty_d  = '0;
      br_up_d    = 1'b1;
    end else if (tick) begin
      step_cnt_d = step ? '0 : step_cnt_q + PERIOD_W'(1);
      if (step) begin
        phase_d = ~phase_q;
        chase_d = (chase_q << 1) | (chase_q >> (NUM_LED - 1));
        if (br_up_q) begin
          br_duty_d = br_duty_q + PWM_W'(1);
          if (br_duty_q == PWM_LAST) br_up_d = 1'b0;
        end else begin
          br_duty_d = br_duty_q - PWM_W'(1);
          if (br_duty_q == PWM_W'(1)) br_up_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    led_d = '0;
    case (mode_q)
      MODE_ON:      led_d = '1;
      MODE_BLINK:   led_d = {NUM_LED{phase_q}};
      MODE_CHASE:   led_d = chase_q;
      MODE_PWM:     led_d = {NUM_LED{pwm_cnt_q < duty_q}};
      MODE_BREATHE: led_d = {NUM_LED{pwm_cnt_q < br_duty_q}};
      default:      led_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q       <= '0;
      pwm_cnt_q     <= '0;
      state_q       <= ST_IDLE;
      pend_mode_q   <= '0;
      pend_period_q <= '0;
      pend_duty_q   <= '0;
      mode_q        <= '0;
      period_q      <= PERIOD_W'(1);
      duty_q        <= '0;
      step_cnt_q    <= '0;
      phase_q       <= 1'b0;
      chase_q       <= NUM_LED'(1);
      br_duty_q     <= '0;
      br_up_q       <= 1'b1;
      led_q         <= '0;
    end else begin
      presc_q       <= tick ? '0 : presc_q + PRE_W'(1);
      // PWM period is 2^PWM_W-1 so that duty = all-ones means always lit.
      pwm_cnt_q     <= (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + PWM_W'(1);
      state_q       <= state_d;
      pend_mode_q   <= pend_mode_d;
      pend_period_q <= pend_period_d;
      pend_duty_q   <= pend_duty_d;
      mode_q        <= mode_d;
      period_q      <= period_d;
      duty_q        <= duty_d;
      step_cnt_q    <= step_cnt_d;
      phase_q       <= phase_d;
      chase_q       <= chase_d;
      br_duty_q     <= br_duty_d;
      br_up_q       <= br_up_d;
      led_q         <= led_d;
    end
  end

  assign cfg.cfg_ready = (state_q == ST_IDLE);
  assign cfg.led       = led_q;
  assign cfg.cur_mode  = mode_q;

  logic unused_max;
  assign unused_max = ^DUTY_MAX;
endmodule
